ccu_snoop_fanout: RTL and testbench
===================================

Name: ccu_snoop_fanout

Overview:
- Downstream neighbour of the CCU write/read snoop controllers.
- Takes one snoop request (AC) from a controller and broadcasts it to up to NoMst cached masters, skipping masters excluded by a mask.
- Collects each targeted master's CR response and merges them into a single CR toward the controller.
- Forwards the CD data burst of exactly one master upstream and silently drains CD bursts from all other data-carrying masters.

Parameters:
NoMst, 4, number of snooped cached masters (1..16)
AddrWidth, 64, snoop address width
DataWidth, 64, CD data width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
ac_valid_i  in  1  snoop request valid from controller
ac_ready_o  out  1  snoop request accepted
ac_addr_i  in  AddrWidth  snoop address
ac_prot_i  in  3  snoop prot
ac_snoop_i  in  4  ACSNOOP code
ac_mask_i  in  NoMst  1 = snoop this master (initiator cleared by controller)
cr_valid_o  out  1  merged response valid
cr_ready_i  in  1  merged response accepted
cr_resp_o  out  5  merged CRRESP {WasUnique,IsShared,PassDirty,Error,DataTransfer}
cd_valid_o  out  1  forwarded data valid
cd_ready_i  in  1  forwarded data accepted
cd_data_o  out  DataWidth  forwarded data
cd_last_o  out  1  forwarded last beat
snp_ac_valid_o  out  NoMst  per-master AC valid
snp_ac_ready_i  in  NoMst  per-master AC ready
snp_ac_addr_o  out  AddrWidth  registered address, shared
snp_ac_prot_o  out  3  registered prot, shared
snp_ac_snoop_o  out  4  registered snoop code, shared
snp_cr_valid_i  in  NoMst  per-master CR valid
snp_cr_ready_o  out  NoMst  per-master CR ready
snp_cr_resp_i  in  5*NoMst  per-master CRRESP, master i at [5i+:5]
snp_cd_valid_i  in  NoMst  per-master CD valid
snp_cd_ready_o  out  NoMst  per-master CD ready
snp_cd_data_i  in  DataWidth*NoMst  per-master CD data
snp_cd_last_i  in  NoMst  per-master CD last

Behaviour:

Reset (rst_i high at a clock edge):
- FSM goes to IDLE; all masks and the merged-response register clear.
- All *_valid_o and *_ready_o are 0; snp_* address, prot and snoop registers are 0.
- Reset mid-transaction abandons it; no drain is attempted.

IDLE:
- ac_ready_o = 1.
- On ac_valid_i && ac_ready_o, register addr, prot, snoop and mask; set pend_ac = pend_cr = ac_mask_i.
- Next state is AC, or RESP with merged = 0 when ac_mask_i == 0.
- Accept-to-snp_ac_valid_o latency: 1 cycle.

AC:
- snp_ac_valid_o = pend_ac.
- Each master's bit clears on its own handshake; masters are independent, and valid stays asserted until that master's ready.
- Move to CR when pend_ac becomes 0 (including the cycle of the last handshake).

CR:
- snp_cr_ready_o = pend_cr.
- On each CR handshake:
  - Clear the master's bit.
  - OR its Error, PassDirty, IsShared and WasUnique into merged.
  - If DataTransfer = 1, set its bit in cd_mask.
  - If DataTransfer = 1, Error = 0 and no master is selected yet, record sel = lowest such index in that cycle.
- Simultaneous CRs in one cycle are all accepted; the lowest index wins selection.
- Merged DataTransfer = a master is selected.
- Move to RESP when pend_cr becomes 0.

RESP:
- cr_valid_o = 1, cr_resp_o = merged register; hold stable until cr_ready_i.
- On handshake, go to CD if cd_mask != 0, otherwise IDLE.

CD:
- Selected master: cd_valid_o = snp_cd_valid_i[sel], cd_data_o and cd_last_o from sel, snp_cd_ready_o[sel] = cd_ready_i.
- Every other master with a cd_mask bit: snp_cd_ready_o = 1, data discarded.
- Each master's cd_mask bit clears on a handshake with last = 1.
- Return to IDLE when cd_mask becomes 0.
- If no master is selected (all data-carrying masters erred), cd_valid_o stays 0 and all bursts drain.
- Burst length is not checked; termination is by last only.

General:
- Combinational outputs depend only on registered state and the *_i valid/ready inputs.
- No combinational path from ac_valid_i to any snp_* output.
- One transaction outstanding; ac_ready_o = 0 outside IDLE.

Test Plan:
- Mask 4'b0000, ac_snoop=0x7 -> no snp_ac_valid_o; cr_valid_o 1 cycle after accept, cr_resp_o=5'b00000; back in IDLE, no CD.
- Mask 4'b1110; masters 1,2,3 raise snp_ac_ready_i in cycles 3,1,5; all CR = 5'b01000 -> each valid drops individually; cr_resp_o=5'b01000; no CD phase.
- Mask 4'b0110; master 1 CR=5'b00101 and master 2 CR=5'b10001 in the same cycle; each sends 4 beats 0xA0..A3 / 0xB0..B3 -> cr_resp_o=5'b10101; upstream sees only 0xA0..A3 with last on beat 4; master 2 fully drained.
- Mask 4'b0011; master 0 CR=5'b00011 (error+data), master 1 CR=5'b00001 -> sel=1, cr_resp_o=5'b00011; master 0's burst drained, master 1's forwarded.
- CD backpressure: cd_ready_i toggles 1,0,1,0 during a 4-beat burst -> snp_cd_ready_o[sel] mirrors it; data, valid and last stable while stalled; the next AC is accepted only after the final last.
- rst_i asserted in CD mid-burst -> next cycle all valids/readies are 0, state IDLE; a new AC is accepted normally afterwards.

Source files
------------

// File: rtl/ccu_snoop_fanout_if.sv
// Snoop fan-out bundle: AC/CR/CD toward the snoop controller plus the per-master
// snp_* channels. The fan-out block uses the slave modport, its environment the master one.
interface ccu_snoop_fanout_if #(
    parameter int NoMst     = 4,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
);
    logic                      ac_valid_i;
    logic                      ac_ready_o;
    logic [AddrWidth-1:0]      ac_addr_i;
    logic [2:0]                ac_prot_i;
    logic [3:0]                ac_snoop_i;
    logic [NoMst-1:0]          ac_mask_i;
    logic                      cr_valid_o;
    logic                      cr_ready_i;
    logic [4:0]                cr_resp_o;
    logic                      cd_valid_o;
    logic                      cd_ready_i;
    logic [DataWidth-1:0]      cd_data_o;
    logic                      cd_last_o;
    logic [NoMst-1:0]          snp_ac_valid_o;
    logic [NoMst-1:0]          snp_ac_ready_i;
    logic [AddrWidth-1:0]      snp_ac_addr_o;
    logic [2:0]                snp_ac_prot_o;
    logic [3:0]                snp_ac_snoop_o;
    logic [NoMst-1:0]          snp_cr_valid_i;
    logic [NoMst-1:0]          snp_cr_ready_o;
    logic [5*NoMst-1:0]        snp_cr_resp_i;
    logic [NoMst-1:0]          snp_cd_valid_i;
    logic [NoMst-1:0]          snp_cd_ready_o;
    logic [DataWidth*NoMst-1:0] snp_cd_data_i;
    logic [NoMst-1:0]          snp_cd_last_i;

    modport slave (
        input  ac_valid_i, ac_addr_i, ac_prot_i, ac_snoop_i, ac_mask_i,
        output ac_ready_o,
        output cr_valid_o, cr_resp_o,
        input  cr_ready_i,
        output cd_valid_o, cd_data_o, cd_last_o,
        input  cd_ready_i,
        output snp_ac_valid_o, snp_ac_addr_o, snp_ac_prot_o, snp_ac_snoop_o,
        input  snp_ac_ready_i,
        input  snp_cr_valid_i, snp_cr_resp_i,
        output snp_cr_ready_o,
        input  snp_cd_valid_i, snp_cd_data_i, snp_cd_last_i,
        output snp_cd_ready_o
    );

    modport master (
        output ac_valid_i, ac_addr_i, ac_prot_i, ac_snoop_i, ac_mask_i,
        input  ac_ready_o,
        input  cr_valid_o, cr_resp_o,
        output cr_ready_i,
        input  cd_valid_o, cd_data_o, cd_last_o,
        output cd_ready_i,
        input  snp_ac_valid_o, snp_ac_addr_o, snp_ac_prot_o, snp_ac_snoop_o,
        output snp_ac_ready_i,
        output snp_cr_valid_i, snp_cr_resp_i,
        input  snp_cr_ready_o,
        output snp_cd_valid_i, snp_cd_data_i, snp_cd_last_i,
        input  snp_cd_ready_o
    );
endinterface

// File: rtl/ccu_snoop_fanout.sv
// Broadcasts one snoop to the masked cached masters, merges their CR responses and
// forwards the CD burst of the first clean data-carrying master while draining the rest.
module ccu_snoop_fanout #(
    parameter int NoMst     = 4,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ccu_snoop_fanout_if.slave  bus
);
    localparam int SelW = (NoMst > 1) ? $clog2(NoMst) : 1;

    typedef enum logic [2:0] {S_IDLE, S_AC, S_CR, S_RESP, S_CD} state_t;

    state_t               r_state, w_state_nxt;
    logic [AddrWidth-1:0] r_addr;
    logic [2:0]           r_prot;
    logic [3:0]           r_snoop;
    logic [NoMst-1:0]     r_pend_ac, r_pend_cr, r_cd_mask;
    logic [3:0]           r_merged;     // {WasUnique, IsShared, PassDirty, Error}
    logic                 r_sel_vld;
    logic [SelW-1:0]      r_sel;

    logic [NoMst-1:0]     w_ac_hs, w_cr_hs, w_cr_dt, w_cr_cand, w_cd_done;
    logic [3:0]           w_cr_or;
    logic                 w_cand_any;
    logic [SelW-1:0]      w_cand_idx;

    always_comb begin
        w_ac_hs    = (r_state == S_AC) ? (r_pend_ac & bus.snp_ac_ready_i) : '0;
        w_cr_hs    = (r_state == S_CR) ? (r_pend_cr & bus.snp_cr_valid_i) : '0;
        w_cr_or    = '0;
        w_cr_dt    = '0;
        w_cr_cand  = '0;
        w_cand_any = 1'b0;
        w_cand_idx = '0;
        for (int i = 0; i < NoMst; i++) begin
            w_cr_dt[i]   = bus.snp_cr_resp_i[5*i];
            w_cr_cand[i] = w_cr_hs[i] & bus.snp_cr_resp_i[5*i] & ~bus.snp_cr_resp_i[5*i+1];
            if (w_cr_hs[i])
                w_cr_or = w_cr_or | bus.snp_cr_resp_i[5*i+1 +: 4];
        end
        // Descending scan so the lowest candidate index wins.
        for (int i = NoMst - 1; i >= 0; i--) begin
            if (w_cr_cand[i]) begin
                w_cand_any = 1'b1;
                w_cand_idx = SelW'(i);
            end
        end
        w_cd_done = bus.snp_cd_valid_i & bus.snp_cd_ready_o & bus.snp_cd_last_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.ac_valid_i)
                        w_state_nxt = (bus.ac_mask_i == '0) ? S_RESP : S_AC;
            S_AC:   if ((r_pend_ac & ~w_ac_hs) == '0) w_state_nxt = S_CR;
            S_CR:   if ((r_pend_cr & ~w_cr_hs) == '0) w_state_nxt = S_RESP;
            S_RESP: if (bus.cr_ready_i)
                        w_state_nxt = (r_cd_mask != '0) ? S_CD : S_IDLE;
            S_CD:   if ((r_cd_mask & ~w_cd_done) == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ac_ready_o     = (r_state == S_IDLE) && !rst_i;
        bus.snp_ac_valid_o = (r_state == S_AC) ? r_pend_ac : '0;
        bus.snp_cr_ready_o = (r_state == S_CR) ? r_pend_cr : '0;
        bus.cr_valid_o     = (r_state == S_RESP);
        bus.cr_resp_o      = (r_state == S_RESP) ? {r_merged, r_sel_vld} : 5'b0;
        bus.cd_valid_o     = 1'b0;
        bus.cd_data_o      = bus.snp_cd_data_i[int'(r_sel)*DataWidth +: DataWidth];
        bus.cd_last_o      = bus.snp_cd_last_i[r_sel];
        bus.snp_cd_ready_o = '0;
        if (r_state == S_CD) begin
            bus.cd_valid_o = r_sel_vld & r_cd_mask[r_sel] & bus.snp_cd_valid_i[r_sel];
            // Non-selected data carriers are drained unconditionally.
            for (int i = 0; i < NoMst; i++) begin
                if (r_sel_vld && (SelW'(i) == r_sel))
                    bus.snp_cd_ready_o[i] = r_cd_mask[i] & bus.cd_ready_i;
                else
                    bus.snp_cd_ready_o[i] = r_cd_mask[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr    <= '0;
            r_prot    <= '0;
            r_snoop   <= '0;
            r_pend_ac <= '0;
            r_pend_cr <= '0;
            r_cd_mask <= '0;
            r_merged  <= '0;
            r_sel_vld <= 1'b0;
            r_sel     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.ac_valid_i) begin
                    r_addr    <= bus.ac_addr_i;
                    r_prot    <= bus.ac_prot_i;
                    r_snoop   <= bus.ac_snoop_i;
                    r_pend_ac <= bus.ac_mask_i;
                    r_pend_cr <= bus.ac_mask_i;
                    r_cd_mask <= '0;
                    r_merged  <= '0;
                    r_sel_vld <= 1'b0;
                    r_sel     <= '0;
                end
                S_AC: r_pend_ac <= r_pend_ac & ~w_ac_hs;
                S_CR: begin
                    r_pend_cr <= r_pend_cr & ~w_cr_hs;
                    r_merged  <= r_merged | w_cr_or;
                    r_cd_mask <= r_cd_mask | (w_cr_hs & w_cr_dt);
                    if (!r_sel_vld && w_cand_any) begin
                        r_sel_vld <= 1'b1;
                        r_sel     <= w_cand_idx;
                    end
                end
                S_CD: r_cd_mask <= r_cd_mask & ~w_cd_done;
                default: ;
            endcase
        end
    end

    assign bus.snp_ac_addr_o  = r_addr;
    assign bus.snp_ac_prot_o  = r_prot;
    assign bus.snp_ac_snoop_o = r_snoop;
endmodule

// File: tb/tb_ccu_snoop_fanout.sv
// Directed bench for ccu_snoop_fanout: each scenario task drives a snoop end to end
// and compares outputs against hand-computed values.
module tb_ccu_snoop_fanout;
    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    ccu_snoop_fanout_if #(.NoMst(N), .AddrWidth(AW), .DataWidth(DW)) bus ();

    ccu_snoop_fanout #(.NoMst(N), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // CD burst model: per-master beat counter, start cycle, data base
    int         bt[N];
    int         st[N];
    logic [7:0] base[N];
    logic [N-1:0] dm;
    int         sel;
    int         rc[N] = '{0, 3, 1, 5};
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_v;
    logic [DW-1:0] exp_d;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ac_valid_i     = 1'b0;
        bus.ac_addr_i      = '0;
        bus.ac_prot_i      = '0;
        bus.ac_snoop_i     = '0;
        bus.ac_mask_i      = '0;
        bus.cr_ready_i     = 1'b0;
        bus.cd_ready_i     = 1'b0;
        bus.snp_ac_ready_i = '0;
        bus.snp_cr_valid_i = '0;
        bus.snp_cr_resp_i  = '0;
        bus.snp_cd_valid_i = '0;
        bus.snp_cd_data_i  = '0;
        bus.snp_cd_last_i  = '0;
    endtask

    task automatic accept_ac(input logic [N-1:0] m, input logic [AW-1:0] a,
                             input logic [3:0] sn);
        bus.ac_valid_i = 1'b1;
        bus.ac_mask_i  = m;
        bus.ac_addr_i  = a;
        bus.ac_prot_i  = 3'b010;
        bus.ac_snoop_i = sn;
        tick();
        bus.ac_valid_i = 1'b0;
    endtask

    task automatic ac_all_ready();
        bus.snp_ac_ready_i = '1;
        tick();
        bus.snp_ac_ready_i = '0;
    endtask

    task automatic set_cr(input logic [N-1:0] v, input logic [4:0] r0, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] r3);
        bus.snp_cr_valid_i = v;
        bus.snp_cr_resp_i  = {r3, r2, r1, r0};
    endtask

    task automatic resp_hs();
        bus.cr_ready_i = 1'b1;
        tick();
        bus.cr_ready_i = 1'b0;
    endtask

    task automatic cd_setup(input logic [N-1:0] m, input int s);
        dm  = m;
        sel = s;
        for (int i = 0; i < N; i++) begin
            bt[i] = 0;
            st[i] = 0;
        end
    endtask

    task automatic cd_drive(input int c);
        for (int i = 0; i < N; i++) begin
            bus.snp_cd_valid_i[i] = dm[i] && (c >= st[i]) && (bt[i] < 4);
            bus.snp_cd_data_i[i*DW +: DW] = {56'h0, base[i]} + 64'(bt[i]);
            bus.snp_cd_last_i[i] = (bt[i] == 3);
        end
    endtask

    function automatic logic [N-1:0] cd_exp_rdy(input logic r);
        logic [N-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++)
            if (dm[i] && bt[i] < 4) e[i] = (i == sel) ? r : 1'b1;
        return e;
    endfunction

    task automatic cd_advance(input logic [N-1:0] r);
        for (int i = 0; i < N; i++)
            if (bus.snp_cd_valid_i[i] && r[i]) bt[i]++;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        @(negedge clk_i);
        n_vec++;
        if ({bus.ac_ready_o, bus.cr_valid_o, bus.cd_valid_o, bus.snp_ac_valid_o,
             bus.snp_cr_ready_o, bus.snp_cd_ready_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_handshakes: got ac_rdy=%b cr_v=%b cd_v=%b ac_v=%b cr_r=%b cd_r=%b want all 0",
                     bus.ac_ready_o, bus.cr_valid_o, bus.cd_valid_o, bus.snp_ac_valid_o,
                     bus.snp_cr_ready_o, bus.snp_cd_ready_o);
        end
        n_vec++;
        if ({bus.snp_ac_addr_o, bus.snp_ac_prot_o, bus.snp_ac_snoop_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_regs: got addr=%h prot=%h snoop=%h want 0",
                     bus.snp_ac_addr_o, bus.snp_ac_prot_o, bus.snp_ac_snoop_o);
        end
        rst_i = 1'b0;
        tick();
        @(negedge clk_i);
        n_vec++;
        if (bus.ac_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_idle_ready: got %b want 1", bus.ac_ready_o);
        end
    endtask

    task automatic test_mask_zero();
        tick();
        bus.ac_valid_i = 1'b1;
        bus.ac_mask_i  = '0;
        @(negedge clk_i);
        n_vec++;
        if (bus.ac_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL mz_ac_ready: got %b want 1", bus.ac_ready_o);
        end
        bus.ac_valid_i = 1'b0;
        accept_ac('0, 64'h1000, 4'h7);
        @(negedge clk_i);
        n_vec++;
        if ({bus.cr_valid_o, bus.cr_resp_o, bus.snp_ac_valid_o} !== {1'b1, 5'b00000, 4'b0000}) begin
            n_bad++;
            $display("FAIL mz_resp: got cr_v=%b resp=%b ac_v=%b want 1 00000 0000",
                     bus.cr_valid_o, bus.cr_resp_o, bus.snp_ac_valid_o);
        end
        n_vec++;
        if ({bus.snp_ac_snoop_o, bus.snp_ac_prot_o, bus.snp_ac_addr_o} !== {4'h7, 3'b010, 64'h1000}) begin
            n_bad++;
            $display("FAIL mz_regs: got snoop=%h prot=%b addr=%h want 7 010 1000",
                     bus.snp_ac_snoop_o, bus.snp_ac_prot_o, bus.snp_ac_addr_o);
        end
        resp_hs();
        @(negedge clk_i);
        n_vec++;
        if ({bus.ac_ready_o, bus.cr_valid_o, bus.cd_valid_o, bus.snp_cd_ready_o} !== {3'b100, 4'b0000}) begin
            n_bad++;
            $display("FAIL mz_idle: got ac_rdy=%b cr_v=%b cd_v=%b cd_r=%b want 1 0 0 0000",
                     bus.ac_ready_o, bus.cr_valid_o, bus.cd_valid_o, bus.snp_cd_ready_o);
        end
    endtask

    task automatic test_ac_fanout();
        tick();
        accept_ac(4'b1110, 64'hDEAD_BEEF_0000_0040, 4'h1);
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < N; i++) begin
                bus.snp_ac_ready_i[i] = (rc[i] == k);
                exp_v[i] = (rc[i] >= k);
            end
            @(negedge clk_i);
            n_vec++;
            if (bus.snp_ac_valid_o !== exp_v) begin
                n_bad++;
                $display("FAIL fan_ac_valid cycle %0d: got %b want %b", k, bus.snp_ac_valid_o, exp_v);
            end
            tick();
        end
        bus.snp_ac_ready_i = '0;
        n_vec++;
        if (bus.snp_ac_addr_o !== 64'hDEAD_BEEF_0000_0040) begin
            n_bad++;
            $display("FAIL fan_addr: got %h want deadbeef00000040", bus.snp_ac_addr_o);
        end
        set_cr(4'b1110, 5'b01000, 5'b01000, 5'b01000, 5'b01000);
        @(negedge clk_i);
        n_vec++;
        if ({bus.snp_cr_ready_o, bus.snp_ac_valid_o} !== {4'b1110, 4'b0000}) begin
            n_bad++;
            $display("FAIL fan_cr_ready: got cr_r=%b ac_v=%b want 1110 0000",
                     bus.snp_cr_ready_o, bus.snp_ac_valid_o);
        end
        tick();
        bus.snp_cr_valid_i = '0;
        @(negedge clk_i);
        n_vec++;
        if ({bus.cr_valid_o, bus.cr_resp_o} !== {1'b1, 5'b01000}) begin
            n_bad++;
            $display("FAIL fan_resp: got v=%b resp=%b want 1 01000", bus.cr_valid_o, bus.cr_resp_o);
        end
        resp_hs();
        @(negedge clk_i);
        n_vec++;
        if ({bus.ac_ready_o, bus.snp_cd_ready_o, bus.cd_valid_o} !== {1'b1, 4'b0000, 1'b0}) begin
            n_bad++;
            $display("FAIL fan_no_cd: got ac_rdy=%b cd_r=%b cd_v=%b want 1 0000 0",
                     bus.ac_ready_o, bus.snp_cd_ready_o, bus.cd_valid_o);
        end
    endtask

    task automatic test_data_merge();
        tick();
        accept_ac(4'b0110, 64'h2000, 4'h9);
        ac_all_ready();
        set_cr(4'b0110, 5'b00000, 5'b00101, 5'b10001, 5'b00000);
        @(negedge clk_i);
        n_vec++;
        if (bus.snp_cr_ready_o !== 4'b0110) begin
            n_bad++;
            $display("FAIL dm_cr_ready: got %b want 0110", bus.snp_cr_ready_o);
        end
        tick();
        bus.snp_cr_valid_i = '0;
        @(negedge clk_i);
        n_vec++;
        if (bus.cr_resp_o !== 5'b10101) begin
            n_bad++;
            $display("FAIL dm_resp: got %b want 10101", bus.cr_resp_o);
        end
        cd_setup(4'b0110, 1);
        base[1] = 8'hA0;
        base[2] = 8'hB0;
        st[2]   = 1;
        resp_hs();
        for (int c = 0; c <= 4; c++) begin
            bus.cd_ready_i = 1'b1;
            cd_drive(c);
            exp_rdy = cd_exp_rdy(1'b1);
            exp_d   = 64'hA0 + 64'(bt[1]);
            @(negedge clk_i);
            n_vec++;
            if (bus.cd_valid_o !== (bt[1] < 4)) begin
                n_bad++;
                $display("FAIL dm_cd_valid c%0d: got %b want %b", c, bus.cd_valid_o, (bt[1] < 4));
            end
            if (bt[1] < 4) begin
                n_vec++;
                if ({bus.cd_data_o, bus.cd_last_o} !== {exp_d, (bt[1] == 3)}) begin
                    n_bad++;
                    $display("FAIL dm_cd_beat c%0d: got %h/%b want %h/%b", c, bus.cd_data_o,
                             bus.cd_last_o, exp_d, (bt[1] == 3));
                end
            end
            n_vec++;
            if (bus.snp_cd_ready_o !== exp_rdy) begin
                n_bad++;
                $display("FAIL dm_cd_ready c%0d: got %b want %b", c, bus.snp_cd_ready_o, exp_rdy);
            end
            tick();
            cd_advance(exp_rdy);
        end
        bus.snp_cd_valid_i = '0;
        bus.cd_ready_i     = 1'b0;
        @(negedge clk_i);
        n_vec++;
        if ({bus.ac_ready_o, bus.snp_cd_ready_o} !== {1'b1, 4'b0000}) begin
            n_bad++;
            $display("FAIL dm_idle: got ac_rdy=%b cd_r=%b want 1 0000", bus.ac_ready_o, bus.snp_cd_ready_o);
        end
    endtask

    task automatic test_err_sel();
        tick();
        accept_ac(4'b0011, 64'h3000, 4'h2);
        ac_all_ready();
        set_cr(4'b0011, 5'b00011, 5'b00001, 5'b00000, 5'b00000);
        tick();
        bus.snp_cr_valid_i = '0;
        @(negedge clk_i);
        n_vec++;
        if (bus.cr_resp_o !== 5'b00011) begin
            n_bad++;
            $display("FAIL es_resp: got %b want 00011", bus.cr_resp_o);
        end
        cd_setup(4'b0011, 1);
        base[0] = 8'hC0;
        base[1] = 8'hD0;
        resp_hs();
        for (int c = 0; c <= 3; c++) begin
            bus.cd_ready_i = 1'b1;
            cd_drive(c);
            exp_rdy = cd_exp_rdy(1'b1);
            exp_d   = 64'hD0 + 64'(bt[1]);
            @(negedge clk_i);
            n_vec++;
            if ({bus.cd_valid_o, bus.cd_data_o, bus.cd_last_o} !== {1'b1, exp_d, (bt[1] == 3)}) begin
                n_bad++;
                $display("FAIL es_cd_beat c%0d: got v=%b %h/%b want 1 %h/%b", c, bus.cd_valid_o,
                         bus.cd_data_o, bus.cd_last_o, exp_d, (bt[1] == 3));
            end
            n_vec++;
            if (bus.snp_cd_ready_o !== exp_rdy) begin
                n_bad++;
                $display("FAIL es_cd_ready c%0d: got %b want %b", c, bus.snp_cd_ready_o, exp_rdy);
            end
            tick();
            cd_advance(exp_rdy);
        end
        bus.snp_cd_valid_i = '0;
        bus.cd_ready_i     = 1'b0;
        @(negedge clk_i);
        n_vec++;
        if (bus.ac_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL es_idle: got %b want 1", bus.ac_ready_o);
        end
    endtask

    task automatic test_cd_backpressure();
        tick();
        accept_ac(4'b0100, 64'h4000, 4'h3);
        ac_all_ready();
        set_cr(4'b0100, 5'b00000, 5'b00000, 5'b00001, 5'b00000);
        tick();
        bus.snp_cr_valid_i = '0;
        @(negedge clk_i);
        n_vec++;
        if (bus.cr_resp_o !== 5'b00001) begin
            n_bad++;
            $display("FAIL bp_resp: got %b want 00001", bus.cr_resp_o);
        end
        cd_setup(4'b0100, 2);
        base[2] = 8'hE0;
        resp_hs();
        bus.ac_valid_i = 1'b1;
        bus.ac_mask_i  = '0;
        for (int c = 0; c <= 6; c++) begin
            bus.cd_ready_i = (c % 2 == 0);
            cd_drive(c);
            exp_rdy = cd_exp_rdy(bus.cd_ready_i);
            exp_d   = 64'hE0 + 64'(bt[2]);
            @(negedge clk_i);
            n_vec++;
            if ({bus.cd_valid_o, bus.cd_data_o, bus.cd_last_o} !== {1'b1, exp_d, (bt[2] == 3)}) begin
                n_bad++;
                $display("FAIL bp_cd_beat c%0d: got v=%b %h/%b want 1 %h/%b", c, bus.cd_valid_o,
                         bus.cd_data_o, bus.cd_last_o, exp_d, (bt[2] == 3));
            end
            n_vec++;
            if ({bus.snp_cd_ready_o, bus.ac_ready_o} !== {exp_rdy, 1'b0}) begin
                n_bad++;
                $display("FAIL bp_ready c%0d: got cd_r=%b ac_rdy=%b want %b 0", c,
                         bus.snp_cd_ready_o, bus.ac_ready_o, exp_rdy);
            end
            tick();
            cd_advance(exp_rdy);
        end
        bus.snp_cd_valid_i = '0;
        bus.cd_ready_i     = 1'b0;
        @(negedge clk_i);
        n_vec++;
        if (bus.ac_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_next_ac: got %b want 1", bus.ac_ready_o);
        end
        tick();
        bus.ac_valid_i = 1'b0;
        @(negedge clk_i);
        n_vec++;
        if ({bus.cr_valid_o, bus.cr_resp_o} !== {1'b1, 5'b00000}) begin
            n_bad++;
            $display("FAIL bp_next_resp: got v=%b resp=%b want 1 00000", bus.cr_valid_o, bus.cr_resp_o);
        end
        resp_hs();
    endtask

    task automatic test_reset_mid_cd();
        tick();
        accept_ac(4'b0001, 64'h5000, 4'h4);
        ac_all_ready();
        set_cr(4'b0001, 5'b00001, 5'b00000, 5'b00000, 5'b00000);
        tick();
        bus.snp_cr_valid_i = '0;
        cd_setup(4'b0001, 0);
        base[0] = 8'hF0;
        resp_hs();
        bus.cd_ready_i = 1'b1;
        cd_drive(0);
        @(negedge clk_i);
        n_vec++;
        if ({bus.cd_valid_o, bus.cd_data_o} !== {1'b1, 64'hF0}) begin
            n_bad++;
            $display("FAIL rm_beat0: got v=%b d=%h want 1 f0", bus.cd_valid_o, bus.cd_data_o);
        end
        tick();
        cd_advance(4'b0001);
        cd_drive(1);
        rst_i = 1'b1;
        tick();
        @(negedge clk_i);
        n_vec++;
        if ({bus.ac_ready_o, bus.cr_valid_o, bus.cd_valid_o, bus.snp_ac_valid_o,
             bus.snp_cr_ready_o, bus.snp_cd_ready_o, bus.snp_ac_addr_o} !== '0) begin
            n_bad++;
            $display("FAIL rm_reset: got ac_rdy=%b cr_v=%b cd_v=%b ac_v=%b cr_r=%b cd_r=%b addr=%h want all 0",
                     bus.ac_ready_o, bus.cr_valid_o, bus.cd_valid_o, bus.snp_ac_valid_o,
                     bus.snp_cr_ready_o, bus.snp_cd_ready_o, bus.snp_ac_addr_o);
        end
        rst_i = 1'b0;
        bus.snp_cd_valid_i = '0;
        bus.cd_ready_i     = 1'b0;
        tick();
        @(negedge clk_i);
        n_vec++;
        if ({bus.ac_ready_o, bus.snp_cd_ready_o} !== {1'b1, 4'b0000}) begin
            n_bad++;
            $display("FAIL rm_idle: got ac_rdy=%b cd_r=%b want 1 0000", bus.ac_ready_o, bus.snp_cd_ready_o);
        end
        accept_ac(4'b0001, 64'h80, 4'h5);
        @(negedge clk_i);
        n_vec++;
        if ({bus.snp_ac_valid_o, bus.snp_ac_addr_o} !== {4'b0001, 64'h80}) begin
            n_bad++;
            $display("FAIL rm_new_ac: got v=%b addr=%h want 0001 80", bus.snp_ac_valid_o, bus.snp_ac_addr_o);
        end
        ac_all_ready();
        set_cr(4'b0001, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        tick();
        bus.snp_cr_valid_i = '0;
        @(negedge clk_i);
        n_vec++;
        if ({bus.cr_valid_o, bus.cr_resp_o} !== {1'b1, 5'b00000}) begin
            n_bad++;
            $display("FAIL rm_new_resp: got v=%b resp=%b want 1 00000", bus.cr_valid_o, bus.cr_resp_o);
        end
        resp_hs();
        @(negedge clk_i);
        n_vec++;
        if ({bus.ac_ready_o, bus.snp_cd_ready_o} !== {1'b1, 4'b0000}) begin
            n_bad++;
            $display("FAIL rm_new_idle: got ac_rdy=%b cd_r=%b want 1 0000", bus.ac_ready_o, bus.snp_cd_ready_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mask_zero();
        test_ac_fanout();
        test_data_merge();
        test_err_sel();
        test_cd_backpressure();
        test_reset_mid_cd();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
